spi_slave_param: RTL

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync.sv | 24 ++
 rtl/spi_slave_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI slave
package spi_pkg;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    localparam int DW_MIN   = 2;
    localparam int DW_MAX   = 32;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-stage flop synchronizer with configurable reset value
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {N{RST_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - oversampled SPI slave, all four modes, one-word tx holding register
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DW          = 8,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          SCLK,
    input  logic          MOSI,
    input  logic          CS,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          MISO,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          underrun,
    output logic          busy
);

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    function automatic logic first_bit(input logic [DW-1:0] w);
        return (MSB_FIRST != 0) ? w[DW-1] : w[0];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w);
        return (MSB_FIRST != 0) ? {w[DW-2:0], 1'b0} : {1'b0, w[DW-1:1]};
    endfunction

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[DW-2:0], b} : {b, w[DW-1:1]};
    endfunction

    logic sclk_s, mosi_s, cs_s;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(CLK), .rst_i(reset), .d_i(SCLK), .q_o(sclk_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(CLK), .rst_i(reset), .d_i(MOSI), .q_o(mosi_s)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(CLK), .rst_i(reset), .d_i(CS), .q_o(cs_s)
    );

    spi_state_e    state_q;
    logic [1:0]    mode_q;
    logic          sclk_prev_q;
    logic [DW-1:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [DW-1:0] tx_sr_q, tx_sr_d;
    logic          miso_q, miso_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          underrun_q, underrun_d;
    logic          pend_q, pend_d;

    logic          sclk_rise, sclk_fall, run, samp_on_rise;
    logic          sample_edge, shift_edge, last_sample, cpha, cs_fall, load;
    logic [DW-1:0] load_word;

    assign sclk_rise    = sclk_s & ~sclk_prev_q;
    assign sclk_fall    = ~sclk_s & sclk_prev_q;
    assign cs_fall      = (state_q == ST_IDLE) && !cs_s;
    assign run          = (state_q == ST_ACTIVE) && !cs_s;
    assign cpha         = mode_q[MODE_CPHA];
    assign samp_on_rise = (mode_q[MODE_CPOL] == mode_q[MODE_CPHA]);
    assign sample_edge  = run && (samp_on_rise ? sclk_rise : sclk_fall);
    assign shift_edge   = run && (samp_on_rise ? sclk_fall : sclk_rise);
    assign last_sample  = sample_edge && (bit_cnt_q == CNT_LAST);

    // CPHA=0 defers the next-word load to the shift edge after the last sample.
    assign load = cs_fall
               || (cpha && last_sample)
               || (!cpha && shift_edge && pend_q);

    assign load_word = hold_full_q ? hold_q : (tx_valid ? tx_data : '0);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cs_s) begin
                        state_q <= ST_ACTIVE;
                        mode_q  <= mode;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        pend_d      = pend_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            pend_d    = 1'b0;
            if (cs_fall) begin
                rx_sr_d = '0;
                tx_sr_d = load_word;
                if (!mode[MODE_CPHA]) begin
                    miso_d = first_bit(load_word);
                end
            end
        end else if (cs_s) begin
            // Deselect wins over any edge seen in the same cycle.
            bit_cnt_d = '0;
            tx_sr_d   = '0;
            miso_d    = 1'b0;
            pend_d    = 1'b0;
        end else begin
            if (sample_edge) begin
                rx_sr_d = shift_in(rx_sr_q, mosi_s);
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d  = '0;
                    rx_data_d  = rx_sr_d;
                    rx_valid_d = 1'b1;
                    if (cpha) begin
                        tx_sr_d = load_word;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (shift_edge) begin
                if (cpha) begin
                    miso_d  = first_bit(tx_sr_q);
                    tx_sr_d = shift_out(tx_sr_q);
                end else if (pend_q) begin
                    tx_sr_d = load_word;
                    miso_d  = first_bit(load_word);
                    pend_d  = 1'b0;
                end else begin
                    tx_sr_d = shift_out(tx_sr_q);
                    miso_d  = first_bit(tx_sr_d);
                end
            end
        end

        if (load) begin
            hold_full_d = 1'b0;
            underrun_d  = !hold_full_q && !tx_valid;
        end else if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_sr_q     <= '0;
            miso_q      <= 1'b0;
            pend_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_ready = !hold_full_q;
    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign busy     = !cs_s;

endmodule
